// File: rtl/line_draw_scheduler_pkg.sv
// Shared definitions for the line-draw scheduler: default widths, FSM encoding, drawer handshake levels.
// Pure declarations; no logic.
// No flow control of its own.
package line_draw_scheduler_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // drw_in_rtr level meaning the drawer is idle and can take a new line
    localparam logic DRW_IDLE = 1'b1;

endpackage

// File: rtl/line_draw_scheduler_rr_arbiter.sv
// Round-robin picker: first requester after last_grant (modulo NUM_REQ) wins.
// Latency: combinational.
// No backpressure; caller decides whether the grant is used.
module rr_arbiter
    import line_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/line_draw_scheduler.sv
// Shares one line drawer between NUM_REQ command sources; tags pixels with colour and source id.
// Latency: accept T, drawer launch T+1, pixels from T+3; next accept after DONE.
// Backpressure: px_rtr feeds drw_out_rtr directly, so a stalled pixel is held by the drawer.
module line_draw_scheduler
    import line_draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int COORD_W = line_draw_scheduler_pkg::COORD_W,
    parameter int COLOR_W = line_draw_scheduler_pkg::COLOR_W,
    parameter int PXCNT_W = 11
) (
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [NUM_REQ-1:0]         req_rts,
    output logic [NUM_REQ-1:0]         req_rtr,
    input  logic [NUM_REQ*COORD_W-1:0] req_x1,
    input  logic [NUM_REQ*COORD_W-1:0] req_y1,
    input  logic [NUM_REQ*COORD_W-1:0] req_x2,
    input  logic [NUM_REQ*COORD_W-1:0] req_y2,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [COORD_W-1:0]         drw_x1,
    output logic [COORD_W-1:0]         drw_y1,
    output logic [COORD_W-1:0]         drw_x2,
    output logic [COORD_W-1:0]         drw_y2,
    output logic                       drw_in_rts,
    input  logic                       drw_in_rtr,
    input  logic                       drw_out_rts,
    output logic                       drw_out_rtr,
    input  logic [COORD_W-1:0]         drw_x,
    input  logic [COORD_W-1:0]         drw_y,
    output logic                       px_rts,
    input  logic                       px_rtr,
    output logic [COORD_W-1:0]         px_x,
    output logic [COORD_W-1:0]         px_y,
    output logic [COLOR_W-1:0]         px_color,
    output logic [ID_W-1:0]            px_src,
    output logic                       busy,
    output logic                       line_done,
    output logic [PXCNT_W-1:0]         line_pxcnt,
    output logic [15:0]                lines_total
);

    typedef struct packed {
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
        logic [COLOR_W-1:0] color;
    } cmd_t;

    sched_state_t       state_q;
    logic               run_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    src_q;
    cmd_t               cmd_q;
    logic [PXCNT_W-1:0] pxcnt_q;
    logic [PXCNT_W-1:0] pxcnt_nxt;
    logic               line_done_q;
    logic [PXCNT_W-1:0] line_pxcnt_q;
    logic [15:0]        total_q;

    cmd_t               req_cmd [NUM_REQ];
    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_id;
    logic               arb_any;
    logic               accept;
    logic               px_xfc;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_cmd[g] = {req_x1[g*COORD_W +: COORD_W], req_y1[g*COORD_W +: COORD_W],
                             req_x2[g*COORD_W +: COORD_W], req_y2[g*COORD_W +: COORD_W],
                             req_color[g*COLOR_W +: COLOR_W]};
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req        (req_rts),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_id   (arb_id),
        .any        (arb_any)
    );

    // run_q keeps req_rtr low through reset and the first cycle after release
    assign accept = (state_q == ST_IDLE) && run_q && arb_any;

    always_comb begin
        req_rtr     = '0;
        drw_in_rts  = 1'b0;
        px_rts      = 1'b0;
        drw_out_rtr = 1'b0;
        case (state_q)
            ST_IDLE:  req_rtr = accept ? arb_grant : '0;
            ST_ISSUE: drw_in_rts = 1'b1;
            ST_DRAW: begin
                px_rts      = drw_out_rts;
                drw_out_rtr = px_rtr;
            end
            default: ;
        endcase
    end

    assign px_xfc    = px_rts && px_rtr;
    assign pxcnt_nxt = (px_xfc && (pxcnt_q != '1)) ? pxcnt_q + 1'b1 : pxcnt_q;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            src_q        <= '0;
            cmd_q        <= '0;
            pxcnt_q      <= '0;
            line_done_q  <= 1'b0;
            line_pxcnt_q <= '0;
            total_q      <= '0;
        end else begin
            run_q       <= 1'b1;
            line_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q   <= req_cmd[arb_id];
                        src_q   <= arb_id;
                        pxcnt_q <= '0;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (drw_in_rtr == DRW_IDLE) state_q <= ST_DRAW;
                end
                ST_DRAW: begin
                    pxcnt_q <= pxcnt_nxt;
                    // status is loaded on entry to DONE so it is valid alongside line_done
                    if (drw_in_rtr == DRW_IDLE) begin
                        state_q      <= ST_DONE;
                        line_done_q  <= 1'b1;
                        line_pxcnt_q <= pxcnt_nxt;
                        total_q      <= total_q + 16'd1;
                    end
                end
                default: begin
                    last_grant_q <= src_q;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign drw_x1      = cmd_q.x1;
    assign drw_y1      = cmd_q.y1;
    assign drw_x2      = cmd_q.x2;
    assign drw_y2      = cmd_q.y2;
    assign px_x        = drw_x;
    assign px_y        = drw_y;
    assign px_color    = cmd_q.color;
    assign px_src      = src_q;
    assign busy        = (state_q != ST_IDLE);
    assign line_done   = line_done_q;
    assign line_pxcnt  = line_pxcnt_q;
    assign lines_total = total_q;

endmodule

// File: tb/tb_line_draw_scheduler.sv
// Bench for line_draw_scheduler: behavioural drawer, per-cycle reference model, directed scenarios.
module tb_line_draw_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int CW  = 10;
    localparam int KW  = 12;
    localparam int PW  = 11;

    logic            clk;
    logic            rst_;
    logic [N-1:0]    req_rts;
    logic [N-1:0]    req_rtr;
    logic [N*CW-1:0] req_x1, req_y1, req_x2, req_y2;
    logic [N*KW-1:0] req_color;
    logic [CW-1:0]   drw_x1, drw_y1, drw_x2, drw_y2;
    logic            drw_in_rts, drw_in_rtr, drw_out_rts, drw_out_rtr;
    logic [CW-1:0]   drw_x, drw_y;
    logic            px_rts, px_rtr;
    logic [CW-1:0]   px_x, px_y;
    logic [KW-1:0]   px_color;
    logic [IDW-1:0]  px_src;
    logic            busy, line_done;
    logic [PW-1:0]   line_pxcnt;
    logic [15:0]     lines_total;

    line_draw_scheduler #(.NUM_REQ(N), .ID_W(IDW), .COORD_W(CW), .COLOR_W(KW), .PXCNT_W(PW)) dut (
        .clk(clk), .rst_(rst_), .req_rts(req_rts), .req_rtr(req_rtr),
        .req_x1(req_x1), .req_y1(req_y1), .req_x2(req_x2), .req_y2(req_y2), .req_color(req_color),
        .drw_x1(drw_x1), .drw_y1(drw_y1), .drw_x2(drw_x2), .drw_y2(drw_y2),
        .drw_in_rts(drw_in_rts), .drw_in_rtr(drw_in_rtr), .drw_out_rts(drw_out_rts), .drw_out_rtr(drw_out_rtr),
        .drw_x(drw_x), .drw_y(drw_y), .px_rts(px_rts), .px_rtr(px_rtr), .px_x(px_x), .px_y(px_y),
        .px_color(px_color), .px_src(px_src), .busy(busy), .line_done(line_done),
        .line_pxcnt(line_pxcnt), .lines_total(lines_total)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL timeout %s: got no event, expected one within budget at %0t", nm, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Ideal line rasteriser: step the major axis, round the minor axis to nearest.
    function automatic logic [2*CW-1:0] line_px(input int x1, input int y1, input int x2, input int y2, input int i);
        int dx, dy, adx, ady, sx, sy, maj, x, y;
        dx  = x2 - x1;
        dy  = y2 - y1;
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        sx  = (dx < 0) ? -1 : 1;
        sy  = (dy < 0) ? -1 : 1;
        maj = (adx > ady) ? adx : ady;
        if (maj == 0) begin
            x = x1;
            y = y1;
        end else if (adx >= ady) begin
            x = x1 + sx * i;
            y = y1 + sy * ((2 * i * ady + maj) / (2 * maj));
        end else begin
            y = y1 + sy * i;
            x = x1 + sx * ((2 * i * adx + maj) / (2 * maj));
        end
        return {CW'(x), CW'(y)};
    endfunction

    function automatic int line_len(input int x1, input int y1, input int x2, input int y2);
        int adx, ady;
        adx = (x2 > x1) ? x2 - x1 : x1 - x2;
        ady = (y2 > y1) ? y2 - y1 : y1 - y2;
        return ((adx > ady) ? adx : ady) + 1;
    endfunction

    // Behavioural line drawer sharing rst_ with the scheduler.
    logic launch, oxfc, d_busy;
    int   d_i, d_len, d_x1, d_y1, d_x2, d_y2;

    initial begin
        drw_in_rtr  = 1'b1;
        drw_out_rts = 1'b0;
        drw_x = '0;
        drw_y = '0;
        d_busy = 1'b0;
        d_i = 0;
        d_len = 0;
        forever begin
            @(negedge clk);
            launch = drw_in_rts && drw_in_rtr;
            oxfc   = drw_out_rts && drw_out_rtr;
            if (launch) begin
                d_x1 = int'(drw_x1); d_y1 = int'(drw_y1);
                d_x2 = int'(drw_x2); d_y2 = int'(drw_y2);
            end
            tick;
            if (!rst_) begin
                d_busy = 1'b0;
                drw_in_rtr  = 1'b1;
                drw_out_rts = 1'b0;
            end else if (launch) begin
                d_busy = 1'b1;
                d_i = 0;
                d_len = line_len(d_x1, d_y1, d_x2, d_y2);
                drw_in_rtr  = 1'b0;
                drw_out_rts = 1'b0;
            end else if (d_busy) begin
                if (oxfc) d_i++;
                if (d_i < d_len) begin
                    drw_out_rts = 1'b1;
                    {drw_x, drw_y} = line_px(d_x1, d_y1, d_x2, d_y2, d_i);
                end else begin
                    drw_out_rts = 1'b0;
                    d_busy = 1'b0;
                    drw_in_rtr = 1'b1;
                end
            end
        end
    end

    // Framebuffer readiness: always ready, or the 1,0,0,1 stall pattern.
    logic       bp_mode = 1'b0;
    logic [3:0] bp_pat  = 4'b1001;
    int         bp_cyc  = 0;

    initial begin
        px_rtr = 1'b1;
        forever begin
            tick;
            px_rtr = bp_mode ? bp_pat[bp_cyc % 4] : 1'b1;
            bp_cyc++;
        end
    end

    // Reference model of the scheduler and the single compare process.
    int   m_phase, m_last, m_src, m_i, m_len, m_x1, m_y1, m_x2, m_y2, m_col, exp_g;
    logic [15:0] m_total;
    logic m_run;
    logic [N-1:0] exp_rtr;
    logic [2*CW-1:0] ep;
    int   cap_x[$], cap_y[$], cap_c[$], cap_s[$], cap_g[$];
    int   preset_ev = 0, seen_ev = 0;
    logic [15:0] total_preset = '0;

    initial begin
        m_phase = 0; m_last = N - 1; m_total = '0; m_run = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                chk("rst_busy", busy, 0);
                chk("rst_px_rts", px_rts, 0);
                chk("rst_req_rtr", req_rtr, 0);
                chk("rst_drw_in_rts", drw_in_rts, 0);
                chk("rst_drw_out_rtr", drw_out_rtr, 0);
                chk("rst_line_done", line_done, 0);
                chk("rst_lines_total", lines_total, 0);
                m_phase = 0; m_last = N - 1; m_total = '0; m_run = 1'b0;
                continue;
            end
            if (preset_ev != seen_ev) begin
                m_total = total_preset;
                seen_ev = preset_ev;
            end
            exp_g = -1;
            if (m_phase == 0 && m_run)
                for (int k = 1; k <= N; k++)
                    if (exp_g < 0 && req_rts[(m_last + k) % N]) exp_g = (m_last + k) % N;
            exp_rtr = (exp_g >= 0) ? N'(1 << exp_g) : '0;
            chk("req_rtr", req_rtr, exp_rtr);
            chk("busy", busy, m_phase != 0);
            chk("drw_in_rts", drw_in_rts, m_phase == 1);
            chk("drw_out_rtr", drw_out_rtr, (m_phase == 2) && px_rtr);
            chk("px_rts", px_rts, (m_phase == 2) && drw_out_rts);
            chk("line_done", line_done, m_phase == 3);
            if (m_phase == 1) begin
                chk("drw_x1", drw_x1, m_x1);
                chk("drw_y1", drw_y1, m_y1);
                chk("drw_x2", drw_x2, m_x2);
                chk("drw_y2", drw_y2, m_y2);
            end
            if (m_phase == 2 && drw_out_rts) begin
                ep = line_px(m_x1, m_y1, m_x2, m_y2, m_i);
                chk("px_x", px_x, ep[2*CW-1:CW]);
                chk("px_y", px_y, ep[CW-1:0]);
                chk("px_color", px_color, m_col);
                chk("px_src", px_src, m_src);
                if (px_rtr) begin
                    cap_x.push_back(int'(px_x)); cap_y.push_back(int'(px_y));
                    cap_c.push_back(int'(px_color)); cap_s.push_back(int'(px_src));
                    m_i++;
                end
            end
            if (m_phase == 3) begin
                chk("line_pxcnt", line_pxcnt, m_len);
                chk("lines_total", lines_total, m_total);
            end
            case (m_phase)
                0: if (exp_g >= 0) begin
                    for (int k = 0; k < N; k++) if (req_rtr[k]) cap_g.push_back(k);
                    m_src = exp_g; m_i = 0;
                    m_x1 = int'(req_x1[exp_g*CW +: CW]); m_y1 = int'(req_y1[exp_g*CW +: CW]);
                    m_x2 = int'(req_x2[exp_g*CW +: CW]); m_y2 = int'(req_y2[exp_g*CW +: CW]);
                    m_col = int'(req_color[exp_g*KW +: KW]);
                    m_len = line_len(m_x1, m_y1, m_x2, m_y2);
                    m_phase = 1;
                end
                1: if (drw_in_rtr) m_phase = 2;
                2: if (drw_in_rtr) begin
                    m_phase = 3;
                    m_total = m_total + 16'd1;
                end
                default: begin
                    m_last = m_src;
                    m_phase = 0;
                end
            endcase
            m_run = 1'b1;
        end
    end

    task automatic set_cmd(input int r, input int x1, input int y1, input int x2, input int y2, input int col);
        req_x1[r*CW +: CW] = CW'(x1);
        req_y1[r*CW +: CW] = CW'(y1);
        req_x2[r*CW +: CW] = CW'(x2);
        req_y2[r*CW +: CW] = CW'(y2);
        req_color[r*KW +: KW] = KW'(col);
    endtask

    task automatic wait_accept(input int r);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_rtr[r]) begin
                tick;
                req_rts[r] = 1'b0;
                return;
            end
        end
        tmo("accept");
        req_rts[r] = 1'b0;
    endtask

    task automatic wait_done;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (line_done) begin
                tick;
                return;
            end
        end
        tmo("line_done");
    endtask

    task automatic wait_px;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (px_rts) begin
                tick;
                return;
            end
        end
        tmo("px_rts");
    endtask

    task automatic run_line(input int r, input int x1, input int y1, input int x2, input int y2, input int col);
        set_cmd(r, x1, y1, x2, y2, col);
        req_rts[r] = 1'b1;
        wait_accept(r);
        wait_done;
    endtask

    task automatic apply_reset;
        rst_ = 1'b0;
        repeat (3) tick;
        rst_ = 1'b1;
        tick;
    endtask

    int t1_x[4] = '{0, 1, 2, 3};
    int t1_y[4] = '{0, 0, 1, 1};
    int t2_g[5] = '{0, 1, 2, 3, 0};
    int ndone;
    logic found;

    initial begin
        rst_ = 1'b0;
        req_rts = '0;
        req_x1 = '0; req_y1 = '0; req_x2 = '0; req_y2 = '0; req_color = '0;
        #1;
        repeat (3) tick;
        rst_ = 1'b1;
        tick;

        // single requester, shallow diagonal
        cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_s.delete();
        run_line(0, 0, 0, 3, 1, 'hF00);
        chk("t1_npx", cap_x.size(), 4);
        for (int i = 0; i < 4 && i < cap_x.size(); i++) begin
            chk("t1_x", cap_x[i], t1_x[i]);
            chk("t1_y", cap_y[i], t1_y[i]);
            chk("t1_color", cap_c[i], 'hF00);
            chk("t1_src", cap_s[i], 0);
        end
        chk("t1_pxcnt", line_pxcnt, 4);
        chk("t1_total", lines_total, 1);

        // all requesters held, single-pixel lines
        apply_reset;
        cap_g.delete();
        for (int r = 0; r < N; r++) set_cmd(r, r + 1, r + 2, r + 1, r + 2, 'h100 + r);
        req_rts = '1;
        ndone = 0;
        for (int c = 0; c < 400 && ndone < 5; c++) begin
            @(negedge clk);
            if (line_done) ndone++;
        end
        if (ndone < 5) tmo("t2_lines");
        tick;
        req_rts = '0;
        repeat (3) tick;
        chk("t2_ngrant", cap_g.size(), 5);
        for (int i = 0; i < 5 && i < cap_g.size(); i++) chk("t2_grant", cap_g[i], t2_g[i]);
        chk("t2_pxcnt", line_pxcnt, 1);
        chk("t2_total", lines_total, 5);

        // vertical line under framebuffer stalls
        cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_s.delete();
        bp_mode = 1'b1;
        run_line(1, 5, 0, 5, 6, 'h0A5);
        bp_mode = 1'b0;
        chk("t3_npx", cap_x.size(), 7);
        for (int i = 0; i < 7 && i < cap_x.size(); i++) begin
            chk("t3_x", cap_x[i], 5);
            chk("t3_y", cap_y[i], i);
            chk("t3_src", cap_s[i], 1);
        end
        chk("t3_pxcnt", line_pxcnt, 7);

        // request arriving mid-line waits for the following IDLE
        cap_g.delete();
        set_cmd(0, 0, 0, 9, 0, 'h0F0);
        req_rts[0] = 1'b1;
        wait_accept(0);
        wait_px;
        set_cmd(2, 2, 2, 2, 2, 'h00F);
        req_rts[2] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (line_done) found = 1'b1;
            else chk("t4_rtr2_wait", req_rtr[2], 0);
        end
        if (!found) tmo("t4_done");
        tick;
        @(negedge clk);
        chk("t4_grant2", req_rtr, 4'b0100);
        tick;
        req_rts[2] = 1'b0;
        wait_done;
        chk("t4_ngrant", cap_g.size(), 2);
        if (cap_g.size() == 2) begin
            chk("t4_first", cap_g[0], 0);
            chk("t4_second", cap_g[1], 2);
        end

        // reset in the middle of a line
        set_cmd(3, 0, 0, 8, 8, 'hABC);
        req_rts[3] = 1'b1;
        wait_accept(3);
        wait_px;
        rst_ = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_px_rts", px_rts, 0);
        chk("t5_total", lines_total, 0);
        repeat (2) tick;
        rst_ = 1'b1;
        tick;
        cap_x.delete(); cap_y.delete(); cap_c.delete(); cap_s.delete();
        run_line(3, 1, 2, 4, 2, 'h123);
        chk("t5_after_total", lines_total, 1);
        chk("t5_after_pxcnt", line_pxcnt, 4);
        chk("t5_after_npx", cap_x.size(), 4);
        if (cap_x.size() > 0) chk("t5_after_color", cap_c[0], 'h123);

        // line counter wrap from a preset just below the top
        total_preset = 16'hFFFE;
        dut.total_q = 16'hFFFE;
        preset_ev++;
        tick;
        run_line(0, 7, 7, 7, 7, 'h777);
        chk("t6_total_ffff", lines_total, 16'hFFFF);
        run_line(0, 7, 7, 7, 7, 'h777);
        chk("t6_total_wrap", lines_total, 0);
        chk("t6_pxcnt", line_pxcnt, 1);

        repeat (3) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
